// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 decoder bus scheduler: controller states,
// SCI opcode and serial frame lengths.
package mp3_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_BOOT,
    ST_IDLE,
    ST_SHIFT_CMD,
    ST_SHIFT_DATA,
    ST_GAP
  } state_t;

  localparam logic [7:0] SCI_WRITE = 8'h02;
  localparam int CMD_BITS  = 32;
  localparam int DATA_BITS = 16;

  // An SCI register write goes out as opcode, address, value, MSB first.
  function automatic logic [CMD_BITS-1:0] sci_frame(input logic [7:0]  addr,
                                                    input logic [15:0] value);
    return {SCI_WRITE, addr, value};
  endfunction

endpackage

// File: rtl/mp3_shift_out.sv
// Loadable MSB-first serializer. Each bit takes two clocks: SCK low while SI
// takes the new bit, then SCK high with SI held. done pulses on the high half
// of the last bit so the controller can leave the shift state on that edge.
module mp3_shift_out #(
  parameter int WIDTH = 32
) (
  input  logic                         clk_1M,
  input  logic                         rst,
  input  logic                         load,
  input  logic [WIDTH-1:0]             word,
  input  logic [$clog2(WIDTH+1)-1:0]   nbits,
  output logic                         SCK,
  output logic                         SI,
  output logic                         done
);

  localparam int CNT_W = $clog2(WIDTH+1);

  logic             busy;
  logic             phase;
  logic [CNT_W-1:0] bits_left;
  logic [WIDTH-1:0] sreg;

  // Bit/phase sequencing; reset drops any frame in flight so it is never resumed.
  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      busy      <= 1'b0;
      phase     <= 1'b0;
      bits_left <= '0;
    end else if (load) begin
      busy      <= 1'b1;
      phase     <= 1'b0;
      bits_left <= nbits;
    end else if (busy) begin
      phase <= ~phase;
      if (phase) begin
        bits_left <= bits_left - CNT_W'(1);
        if (bits_left == CNT_W'(1))
          busy <= 1'b0;
      end
    end
  end

  // Shift register advances after each SCK-high cycle; output gated by busy.
  always_ff @(posedge clk_1M) begin
    if (load)
      sreg <= word;
    else if (busy && phase)
      sreg <= {sreg[WIDTH-2:0], 1'b0};
  end

  assign SCK  = busy & phase;
  assign SI   = busy & sreg[WIDTH-1];
  assign done = busy & phase & (bits_left == CNT_W'(1));

endmodule

// File: rtl/mp3_bus_sched.sv
// Bus scheduler for a VS10xx-style MP3 decoder: holds the decoder in reset,
// waits for it to boot, then arbitrates SCI register writes against SDI audio
// words and serializes the granted one. Commands win while data is waiting
// only up to MAX_CMD_RUN in a row so audio never starves.
module mp3_bus_sched
  import mp3_pkg::*;
#(
  parameter int RESET_CYCLES = 500000,
  parameter int BOOT_TIMEOUT = 100000,
  parameter int MAX_CMD_RUN  = 4
) (
  input  logic        clk_1M,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        cmd_ack,
  input  logic        data_valid,
  input  logic [15:0] data_word,
  output logic        data_ack,
  input  logic        DREQ,
  output logic        XRSET,
  output logic        XCS,
  output logic        XDCS,
  output logic        SI,
  output logic        SCK,
  output logic        ready,
  output logic        boot_err
);

  localparam int RUN_W = $clog2(MAX_CMD_RUN + 1);
  localparam int SH_W  = $clog2(CMD_BITS + 1);

  state_t              state, state_next;
  logic [31:0]         wait_cnt, wait_next;
  logic [RUN_W-1:0]    run_cnt, run_next;
  logic                boot_err_q, boot_err_next;
  logic                load;
  logic [CMD_BITS-1:0] load_word;
  logic [SH_W-1:0]     load_bits;
  logic                sh_done;
  logic                grant_cmd;

  // Commands may jump ahead of pending data only while the run budget lasts.
  assign grant_cmd = cmd_valid && (!data_valid || (run_cnt < RUN_W'(MAX_CMD_RUN)));

  // Next-state, grant and serializer-load decode.
  always_comb begin
    state_next    = state;
    wait_next     = wait_cnt;
    run_next      = run_cnt;
    boot_err_next = boot_err_q;
    cmd_ack       = 1'b0;
    data_ack      = 1'b0;
    load          = 1'b0;
    load_word     = sci_frame(cmd_addr, cmd_data);
    load_bits     = SH_W'(CMD_BITS);

    case (state)
      ST_HOLD: begin
        if (wait_cnt == 32'(RESET_CYCLES - 1)) begin
          state_next = ST_BOOT;
          wait_next  = '0;
        end else begin
          wait_next = wait_cnt + 32'd1;
        end
      end

      ST_BOOT: begin
        if (DREQ) begin
          state_next = ST_IDLE;
          wait_next  = '0;
        end else if (wait_cnt == 32'(BOOT_TIMEOUT - 1)) begin
          boot_err_next = 1'b1;
          state_next    = ST_IDLE;
          wait_next     = '0;
        end else begin
          wait_next = wait_cnt + 32'd1;
        end
      end

      ST_IDLE: begin
        if (DREQ) begin
          if (grant_cmd) begin
            cmd_ack    = 1'b1;
            load       = 1'b1;
            load_word  = sci_frame(cmd_addr, cmd_data);
            load_bits  = SH_W'(CMD_BITS);
            state_next = ST_SHIFT_CMD;
            if (run_cnt < RUN_W'(MAX_CMD_RUN))
              run_next = run_cnt + RUN_W'(1);
          end else if (data_valid) begin
            data_ack   = 1'b1;
            load       = 1'b1;
            load_word  = {data_word, {(CMD_BITS - DATA_BITS){1'b0}}};
            load_bits  = SH_W'(DATA_BITS);
            state_next = ST_SHIFT_DATA;
            run_next   = '0;
          end
        end
      end

      ST_SHIFT_CMD, ST_SHIFT_DATA: begin
        if (sh_done)
          state_next = ST_GAP;
      end

      ST_GAP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_HOLD;
        wait_next  = '0;
      end
    endcase
  end

  // Controller state register; reset returns to decoder hard-reset hold.
  always_ff @(posedge clk_1M) begin
    if (!rst) begin
      state      <= ST_HOLD;
      wait_cnt   <= '0;
      run_cnt    <= '0;
      boot_err_q <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      run_cnt    <= run_next;
      boot_err_q <= boot_err_next;
    end
  end

  mp3_shift_out #(
    .WIDTH (CMD_BITS)
  ) u_shift (
    .clk_1M (clk_1M),
    .rst    (rst),
    .load   (load),
    .word   (load_word),
    .nbits  (load_bits),
    .SCK    (SCK),
    .SI     (SI),
    .done   (sh_done)
  );

  // Selects decode from a single state, so they can never both be low.
  assign XRSET    = (state != ST_HOLD);
  assign XCS      = (state != ST_SHIFT_CMD);
  assign XDCS     = (state != ST_SHIFT_DATA);
  assign ready    = (state == ST_IDLE);
  assign boot_err = boot_err_q;

endmodule

// File: doc/mp3_bus_sched.md
MP3_BUS_SCHED -- requirements
Module: mp3_bus_sched

Interface
REQ-001 Parameter RESET_CYCLES, default 500000: clk_1M cycles XRSET held low after reset.
REQ-002 Parameter BOOT_TIMEOUT, default 100000: max cycles to wait for DREQ high after XRSET release.
REQ-003 Parameter MAX_CMD_RUN, default 4: consecutive commands allowed while data is pending.
REQ-004 clk_1M  in  1  block clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  SCI register-write request; held until cmd_ack.
REQ-007 cmd_addr  in  8  SCI register address.
REQ-008 cmd_data  in  16  SCI register value.
REQ-009 cmd_ack  out  1  one-cycle pulse; cmd_addr/cmd_data latched this cycle.
REQ-010 data_valid  in  1  SDI word available; held until data_ack.
REQ-011 data_word  in  16  SDI audio word, MSB first.
REQ-012 data_ack  out  1  one-cycle pulse; data_word latched this cycle (requester advances ROM address).
REQ-013 DREQ  in  1  decoder ready for transfer, active-high.
REQ-014 XRSET  out  1  decoder hardware reset, active-low.
REQ-015 XCS  out  1  SCI select, active-low.
REQ-016 XDCS  out  1  SDI select, active-low.
REQ-017 SI  out  1  serial data to decoder.
REQ-018 SCK  out  1  serial clock to decoder.
REQ-019 ready  out  1  high when boot done and state is IDLE.
REQ-020 boot_err  out  1  sticky; set when BOOT_TIMEOUT expires.

Function
REQ-021 States SHALL be HOLD, BOOT, IDLE, SHIFT_CMD, SHIFT_DATA, GAP.
REQ-022 HOLD: XRSET=0 for RESET_CYCLES cycles, then XRSET=1, go to BOOT.
REQ-023 BOOT: go to IDLE on first cycle DREQ=1; after BOOT_TIMEOUT cycles without it set boot_err and go to IDLE anyway.
REQ-024 IDLE with DREQ=0: no ack; no select asserted.
REQ-025 IDLE with DREQ=1: grant cmd if cmd_valid and (not data_valid or run count < MAX_CMD_RUN); else grant data if data_valid.
REQ-026 Grant cycle: pulse matching ack, latch word, go to SHIFT_CMD/SHIFT_DATA; run count +1 on cmd grant, cleared on data grant.
REQ-027 Command frame: 32 bits = 8'h02, cmd_addr, cmd_data, MSB first, XCS=0 throughout.
REQ-028 Data frame: 16 bits of data_word, MSB first, XDCS=0 throughout.
REQ-029 Bit timing: 2 cycles per bit; cycle A SCK=0 with SI updated, cycle B SCK=1 with SI stable; frame = 2*bits cycles (64 cmd, 32 data).
REQ-030 XCS and XDCS SHALL never be low simultaneously.
REQ-031 After last bit go to GAP for 1 cycle: both selects high, SCK=0, then IDLE.
REQ-032 DREQ falling mid-frame SHALL NOT abort the frame; it only blocks the next grant.
REQ-033 Next grant earliest in the cycle after GAP; max throughput one data word per 34 cycles.
REQ-034 Requests arriving in HOLD/BOOT stay pending; no ack until IDLE.

Reset
REQ-035 rst=0 on any clock edge, including mid-frame: XRSET=0, XCS=1, XDCS=1, SCK=0, SI=0, cmd_ack=0, data_ack=0, ready=0, boot_err=0, run count=0, counters=0, state HOLD.
REQ-036 A frame cut by reset SHALL NOT be resumed; its requester must re-request.

Structure
REQ-037 Shared package mp3_pkg: state enumeration, SCI_WRITE opcode 8'h02, CMD_BITS=32, DATA_BITS=16.
REQ-038 One sub-module mp3_shift_out: loadable MSB-first serializer generating SCK/SI and a done pulse, width parameter.

Verification
REQ-039 RESET_CYCLES=10: rst released -> XRSET low exactly 10 cycles, then high; DREQ=1 -> ready next cycle.
REQ-040 cmd 0x0B/0x8080 in IDLE -> cmd_ack 1 cycle, XCS low 64 cycles, SI stream 0x020B8080, XDCS high.
REQ-041 data_word 0xA5C3, DREQ=1 -> data_ack 1 cycle, XDCS low 32 cycles, SI sampled on SCK rise = 0xA5C3.
REQ-042 cmd_valid and data_valid held high -> grants cmd,cmd,cmd,cmd,data repeating; selects never both low.
REQ-043 DREQ dropped at bit 5 of data frame -> frame completes, no further ack until DREQ=1.
REQ-044 BOOT_TIMEOUT=20, DREQ stuck 0 -> boot_err=1 after 20 cycles; rst mid-frame -> all outputs at reset values next cycle.
